// File: rtl/dt_res_scan.sv
// Scans the DT result map in res_RAM: maximum distance, first address of the maximum, nonzero area.
// Optional macro DT_SCAN_SUM_EN adds a running sum of all distance values (port sum).
//
// state | meaning
// IDLE  | waiting for start; last results held
// READ  | one pixel sampled per clk, address advancing
// FIN   | one-cycle done pulse, results final
module dt_res_scan #(
   parameter int N_PIX  = 16384,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              res_rd,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0] res_di,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_addr,
   output logic [ADDR_W:0]   area
`ifdef DT_SCAN_SUM_EN
   ,
   output logic [DATA_W+ADDR_W-1:0] sum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_FIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

   state_t state, state_nxt;
   logic   last_pix;

   assign last_pix = (res_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_READ;
         S_READ:  if (last_pix) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // res_di sampled here was read by the RAM at the preceding negedge for the current res_addr
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_rd   <= 1'b0;
         res_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         max_val  <= '0;
         max_addr <= '0;
         area     <= '0;
`ifdef DT_SCAN_SUM_EN
         sum      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  res_addr <= '0;
                  res_rd   <= 1'b1;
                  busy     <= 1'b1;
                  max_val  <= '0;
                  max_addr <= '0;
                  area     <= '0;
`ifdef DT_SCAN_SUM_EN
                  sum      <= '0;
`endif
               end
            end
            S_READ: begin
               if (res_di > max_val) begin
                  max_val  <= res_di;
                  max_addr <= res_addr;
               end
               if (res_di != '0) area <= area + (ADDR_W+1)'(1);
`ifdef DT_SCAN_SUM_EN
               sum <= sum + (DATA_W+ADDR_W)'(res_di);
`endif
               if (last_pix) begin
                  res_rd <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  res_addr <= res_addr + ADDR_W'(1);
               end
            end
            S_FIN: begin
               done <= 1'b0;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule
